// File: rtl/uparc_fwdu_sb_pkg.sv
`default_nettype none
// ============================================================================
// uparc_fwdu_sb_pkg : shared CPU constants for the forwarding/scoreboard unit
// Rev 1.0
// ============================================================================
package uparc_fwdu_sb_pkg;

  localparam int REGNO_W_DEF = 5;
  localparam int REG_W_DEF   = 32;

  function automatic int fwdu_clog2(input int value);
    int res;
    res = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << res) < value) res = res + 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uparc_fwdu_port_sel.sv
`default_nettype none
// ============================================================================
// uparc_fwdu_port_sel : per-read-port operand priority mux and hazard detect
// Rev 1.0
// ============================================================================
module uparc_fwdu_port_sel import uparc_fwdu_sb_pkg::*; #(
  parameter int REGNO_W = REGNO_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int NSTAGE  = 2
) (
  input  logic [REGNO_W-1:0]        i_src_no,
  input  logic [REG_W-1:0]          i_src_data,
  input  logic [NSTAGE*REGNO_W-1:0] i_stg_rd,
  input  logic [NSTAGE*REG_W-1:0]   i_stg_data,
  input  logic [NSTAGE-1:0]         i_stg_vld,
  input  logic [NSTAGE-1:0]         i_stg_load,
  input  logic                      i_fwd_dis,
  input  logic                      i_byp_vld,
  input  logic [REGNO_W-1:0]        i_byp_rd,
  input  logic [REG_W-1:0]          i_byp_data,
  input  logic [2**REGNO_W-1:0]     i_pend_map,
  output logic [REG_W-1:0]          o_data,
  output logic                      o_hazard
);

  logic w_found;

  always_comb begin
    o_data   = '0;
    o_hazard = 1'b0;
    w_found  = 1'b0;
    if (i_src_no != '0) begin
      // Lowest stage index is the youngest producer and takes priority
      for (int i = 0; i < NSTAGE; i++) begin
        if (!w_found && i_stg_vld[i] && (i_stg_rd[i*REGNO_W +: REGNO_W] == i_src_no)) begin
          w_found = 1'b1;
          if (i_stg_load[i] || i_fwd_dis) o_hazard = 1'b1;
          else                            o_data   = i_stg_data[i*REG_W +: REG_W];
        end
      end
      if (!w_found) begin
        if (i_byp_vld && (i_byp_rd == i_src_no)) begin
          o_data   = i_byp_data;
          o_hazard = i_fwd_dis;
        end else if (i_pend_map[i_src_no]) begin
          o_hazard = 1'b1;
        end else begin
          o_data = i_src_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uparc_fwdu_sb.sv
`default_nettype none
// ============================================================================
// uparc_fwdu_sb : decode-side forwarding unit with pending-load scoreboard
// Rev 1.0
// ============================================================================
module uparc_fwdu_sb import uparc_fwdu_sb_pkg::*; #(
  parameter int REGNO_W = REGNO_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int NRDPORT = 2,
  parameter int NSTAGE  = 2,
  parameter int MAXPEND = 4,
  localparam int CNT_W  = fwdu_clog2(MAXPEND + 1)
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NRDPORT*REGNO_W-1:0] i_src_no,
  input  logic [NRDPORT*REG_W-1:0]   i_src_data,
  input  logic [NSTAGE*REGNO_W-1:0]  i_stg_rd,
  input  logic [NSTAGE*REG_W-1:0]    i_stg_data,
  input  logic [NSTAGE-1:0]          i_stg_vld,
  input  logic [NSTAGE-1:0]          i_stg_load,
  input  logic                       i_ld_issue,
  input  logic [REGNO_W-1:0]         i_ld_issue_rd,
  input  logic                       i_ld_done,
  input  logic [REGNO_W-1:0]         i_ld_done_rd,
  input  logic [REG_W-1:0]           i_ld_done_data,
  input  logic                       i_fwd_dis,
  output logic [NRDPORT*REG_W-1:0]   o_fwd_data,
  output logic                       o_stall,
  output logic [2**REGNO_W-1:0]      o_pend_map,
  output logic [CNT_W-1:0]           o_pend_cnt,
  output logic                       o_pend_full
);

  localparam int NREG = 2**REGNO_W;
  localparam int RC_W = (CNT_W < 2) ? 2 : CNT_W;

  logic [RC_W-1:0]    r_cnt     [NREG];
  logic [RC_W-1:0]    w_cnt_nxt [NREG];
  logic [NREG-1:0]    r_pend_map;
  logic [CNT_W-1:0]   r_pend_cnt;
  logic               w_full;
  logic               w_iss_ok;
  logic               w_done_ok;
  logic               w_byp_vld;
  logic [NRDPORT-1:0] w_hazard;

  assign w_full    = (r_pend_cnt == CNT_W'(MAXPEND));
  assign w_iss_ok  = i_ld_issue && !(w_full && !i_ld_done);
  assign w_done_ok = i_ld_done && (r_pend_cnt != '0);
  // Bypass only the final outstanding load to a register; older returns are stale
  assign w_byp_vld = w_done_ok && (i_ld_done_rd != '0) && r_pend_map[i_ld_done_rd] &&
                     (w_cnt_nxt[i_ld_done_rd] == '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (r != 0) begin
        if (w_iss_ok && (i_ld_issue_rd == REGNO_W'(r)))
          w_cnt_nxt[r] = w_cnt_nxt[r] + RC_W'(1);
        if (w_done_ok && (i_ld_done_rd == REGNO_W'(r)) && (r_cnt[r] != '0))
          w_cnt_nxt[r] = w_cnt_nxt[r] - RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_pend_map <= '0;
      r_pend_cnt <= '0;
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r]      <= w_cnt_nxt[r];
        r_pend_map[r] <= (w_cnt_nxt[r] != '0);
      end
      if (w_iss_ok && !w_done_ok)      r_pend_cnt <= r_pend_cnt + CNT_W'(1);
      else if (!w_iss_ok && w_done_ok) r_pend_cnt <= r_pend_cnt - CNT_W'(1);
    end
  end

  // Simulation-only check: a return with nothing outstanding is a caller bug
  assert property (@(posedge clk) disable iff (!nrst) !(i_ld_done && (r_pend_cnt == '0)));

  generate
    for (genvar p = 0; p < NRDPORT; p++) begin : g_port
      uparc_fwdu_port_sel #(
        .REGNO_W (REGNO_W),
        .REG_W   (REG_W),
        .NSTAGE  (NSTAGE)
      ) u_sel (
        .i_src_no   (i_src_no[p*REGNO_W +: REGNO_W]),
        .i_src_data (i_src_data[p*REG_W +: REG_W]),
        .i_stg_rd   (i_stg_rd),
        .i_stg_data (i_stg_data),
        .i_stg_vld  (i_stg_vld),
        .i_stg_load (i_stg_load),
        .i_fwd_dis  (i_fwd_dis),
        .i_byp_vld  (w_byp_vld),
        .i_byp_rd   (i_ld_done_rd),
        .i_byp_data (i_ld_done_data),
        .i_pend_map (r_pend_map),
        .o_data     (o_fwd_data[p*REG_W +: REG_W]),
        .o_hazard   (w_hazard[p])
      );
    end
  endgenerate

  assign o_stall     = (|w_hazard) || (i_ld_issue && w_full && !i_ld_done);
  assign o_pend_map  = r_pend_map;
  assign o_pend_cnt  = r_pend_cnt;
  assign o_pend_full = w_full;

endmodule
`default_nettype wire

// File: tb/tb_uparc_fwdu_sb.sv
`default_nettype none
// ============================================================================
// tb_uparc_fwdu_sb : directed self-checking bench for uparc_fwdu_sb
// Rev 1.0
// ============================================================================
module tb_uparc_fwdu_sb;

  logic        clk;
  logic        nrst;
  logic [9:0]  src_no;
  logic [63:0] src_data;
  logic [9:0]  stg_rd;
  logic [63:0] stg_data;
  logic [1:0]  stg_vld;
  logic [1:0]  stg_load;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_done;
  logic [4:0]  ld_done_rd;
  logic [31:0] ld_done_data;
  logic        fwd_dis;
  logic [63:0] fwd_data;
  logic        stall;
  logic [31:0] pend_map;
  logic [2:0]  pend_cnt;
  logic        pend_full;

  int n_asrt;
  int n_fail;

  uparc_fwdu_sb dut (
    .clk            (clk),
    .nrst           (nrst),
    .i_src_no       (src_no),
    .i_src_data     (src_data),
    .i_stg_rd       (stg_rd),
    .i_stg_data     (stg_data),
    .i_stg_vld      (stg_vld),
    .i_stg_load     (stg_load),
    .i_ld_issue     (ld_issue),
    .i_ld_issue_rd  (ld_issue_rd),
    .i_ld_done      (ld_done),
    .i_ld_done_rd   (ld_done_rd),
    .i_ld_done_data (ld_done_data),
    .i_fwd_dis      (fwd_dis),
    .o_fwd_data     (fwd_data),
    .o_stall        (stall),
    .o_pend_map     (pend_map),
    .o_pend_cnt     (pend_cnt),
    .o_pend_full    (pend_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asrt = n_asrt + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    nrst = 1'b0; src_no = '0; src_data = {32'h2222_2222, 32'h1111_1111};
    stg_rd = '0; stg_data = '0; stg_vld = '0; stg_load = '0;
    ld_issue = 1'b0; ld_issue_rd = '0; ld_done = 1'b0; ld_done_rd = '0;
    ld_done_data = '0; fwd_dis = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    #1;
    check_eq("rst_map", pend_map, 0);
    check_eq("rst_cnt", pend_cnt, 0);
    check_eq("rst_full", pend_full, 0);
    check_eq("rst_stall", stall, 0);

    // plain register-file path
    src_no = {5'd3, 5'd2}; #1;
    check_eq("rf_p0", fwd_data[31:0], 32'h1111_1111);
    check_eq("rf_p1", fwd_data[63:32], 32'h2222_2222);

    // stage match, youngest wins
    src_no = {5'd0, 5'd5}; stg_vld = 2'b11; stg_rd = {5'd5, 5'd5};
    stg_data = {32'hBBBB, 32'hAAAA}; #1;
    check_eq("stg_young", fwd_data[31:0], 32'hAAAA);
    check_eq("stg_young_stall", stall, 0);
    stg_vld = 2'b10; #1;
    check_eq("stg_old", fwd_data[31:0], 32'hBBBB);

    // stage load hazard
    stg_vld = 2'b11; stg_load = 2'b01; stg_rd = {5'd5, 5'd7}; src_no = {5'd7, 5'd5}; #1;
    check_eq("ldhz_stall", stall, 1);
    check_eq("ldhz_p0", fwd_data[31:0], 32'hBBBB);
    src_no = {5'd0, 5'd5}; #1;
    check_eq("ldhz_r0_stall", stall, 0);
    check_eq("ldhz_r0_data", fwd_data[63:32], 0);
    stg_vld = '0; stg_load = '0; src_no = '0;

    // scoreboard and return bypass
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    check_eq("sb_map1", pend_map, 32'h0000_0200);
    check_eq("sb_cnt1", pend_cnt, 1);
    src_no = {5'd0, 5'd9}; #1;
    check_eq("sb_stall1", stall, 1);
    tick();
    check_eq("sb_stall2", stall, 1);
    tick();
    ld_done = 1'b1; ld_done_rd = 5'd9; ld_done_data = 32'h1234; #1;
    check_eq("sb_byp_data", fwd_data[31:0], 32'h1234);
    check_eq("sb_byp_stall", stall, 0);
    tick();
    ld_done = 1'b0; #1;
    check_eq("sb_map4", pend_map, 0);
    check_eq("sb_cnt4", pend_cnt, 0);
    check_eq("sb_rf_after", fwd_data[31:0], 32'h1111_1111);

    // simultaneous issue and return to the same register
    src_no = '0;
    ld_issue = 1'b1; ld_issue_rd = 5'd3;
    tick(); tick();
    check_eq("sim_cnt2", pend_cnt, 2);
    check_eq("sim_map2", pend_map, 32'h0000_0008);
    ld_done = 1'b1; ld_done_rd = 5'd3; ld_done_data = 32'hDEAD; src_no = {5'd0, 5'd3}; #1;
    check_eq("sim_stale_stall", stall, 1);
    tick();
    ld_issue = 1'b0;
    check_eq("sim_cnt_hold", pend_cnt, 2);
    check_eq("sim_map_hold", pend_map, 32'h0000_0008);
    #1;
    check_eq("sim_drain1_stall", stall, 1);
    tick();
    ld_done_data = 32'hBEEF; fwd_dis = 1'b1; #1;
    check_eq("sim_final_dis_stall", stall, 1);
    fwd_dis = 1'b0; #1;
    check_eq("sim_final_stall", stall, 0);
    check_eq("sim_final_data", fwd_data[31:0], 32'hBEEF);
    tick();
    ld_done = 1'b0; src_no = '0;
    check_eq("sim_cnt0", pend_cnt, 0);

    // register-0 loads are counted but not mapped
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    tick();
    ld_issue = 1'b0;
    check_eq("r0_cnt", pend_cnt, 1);
    check_eq("r0_map", pend_map, 0);
    ld_done = 1'b1; ld_done_rd = 5'd0;
    tick();
    ld_done = 1'b0;
    check_eq("r0_cnt_clr", pend_cnt, 0);

    // fill, overflow attempt, reset
    ld_issue = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ld_issue_rd = 5'(k);
      tick();
    end
    ld_issue_rd = 5'd6; #1;
    check_eq("full_flag", pend_full, 1);
    check_eq("full_cnt", pend_cnt, 4);
    check_eq("full_stall", stall, 1);
    tick();
    ld_issue = 1'b0;
    check_eq("full_cnt_hold", pend_cnt, 4);
    check_eq("full_map", pend_map, 32'h0000_001E);
    nrst = 1'b0;
    tick();
    nrst = 1'b1; #1;
    check_eq("rst2_map", pend_map, 0);
    check_eq("rst2_cnt", pend_cnt, 0);
    check_eq("rst2_full", pend_full, 0);

    // forwarding disabled
    fwd_dis = 1'b1; stg_vld = 2'b10; stg_rd = {5'd4, 5'd0};
    stg_data = {32'hCAFE_F00D, 32'h0}; src_no = {5'd0, 5'd4}; #1;
    check_eq("dbg_stall", stall, 1);
    fwd_dis = 1'b0; #1;
    check_eq("dbg_off_stall", stall, 0);
    check_eq("dbg_off_data", fwd_data[31:0], 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
